// File: rtl/vga_debug_writer.sv
// Sweeps NUM_SLOTS debug words into the VGA text buffer as 8 uppercase ASCII hex chars each.
// Define VGA_DBG_SKIP_UNCHANGED_EN to skip slots whose word matches the one last written.
module vga_debug_writer #(
  parameter int unsigned NUM_SLOTS     = 16,
  parameter int unsigned SLOTS_PER_ROW = 4,
  parameter int unsigned SLOT_STRIDE   = 20,
  parameter int unsigned ROW_CHARS     = 80,
  parameter int unsigned BASE_ADDR     = 168
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    refresh_i,
  input  logic [NUM_SLOTS*32-1:0] dbg_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    wen_o,
  output logic [11:0]             w_addr_o,
  output logic [7:0]              w_data_o
);

  localparam int unsigned SlotW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e           state_q;
  logic [SlotW-1:0] slot_q;
  logic [2:0]       nib_q;
  logic             pending_q;
  logic [31:0]      snap_q;
  logic             busy_q;
  logic             done_q;
  logic             wen_q;
  logic [11:0]      addr_q;
  logic [7:0]       data_q;

  logic [31:0] words [NUM_SLOTS];
  logic [31:0] cur_word;
  logic [31:0] snap_shl;
  logic        skip;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_words
    assign words[g] = dbg_data_i[32*g +: 32];
  end

  assign cur_word = words[slot_q];
  // Left-align the nibble that follows the one just written.
  assign snap_shl = snap_q << {nib_q + 3'd1, 2'b00};

`ifdef VGA_DBG_SKIP_UNCHANGED_EN
  logic [31:0]          shadow_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  assign skip = valid_q[slot_q] && (shadow_q[slot_q] == cur_word);
`else
  assign skip = 1'b0;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [11:0] slot_base(input logic [SlotW-1:0] s);
    int unsigned si;
    int unsigned a;
    si = 32'(s);
    a  = BASE_ADDR + (si / SLOTS_PER_ROW) * ROW_CHARS + (si % SLOTS_PER_ROW) * SLOT_STRIDE;
    return a[11:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      slot_q    <= '0;
      nib_q     <= '0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef VGA_DBG_SKIP_UNCHANGED_EN
      valid_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      wen_q  <= 1'b0;
      // Requests during a sweep collapse into one follow-up sweep.
      if (refresh_i && (state_q != StIdle)) pending_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (refresh_i) begin
            state_q <= StLoad;
            slot_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          snap_q <= cur_word;
          if (skip) begin
            if (slot_q == LastSlot) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              slot_q <= slot_q + 1'b1;
            end
          end else begin
`ifdef VGA_DBG_SKIP_UNCHANGED_EN
            shadow_q[slot_q] <= cur_word;
            valid_q[slot_q]  <= 1'b1;
`endif
            state_q <= StWrite;
            nib_q   <= '0;
            wen_q   <= 1'b1;
            addr_q  <= slot_base(slot_q);
            data_q  <= hex_char(cur_word[31:28]);
          end
        end
        StWrite: begin
          if (nib_q == 3'd7) begin
            if (slot_q == LastSlot) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StLoad;
              slot_q  <= slot_q + 1'b1;
            end
          end else begin
            nib_q  <= nib_q + 3'd1;
            wen_q  <= 1'b1;
            addr_q <= addr_q + 12'd1;
            data_q <= hex_char(snap_shl[31:28]);
          end
        end
        StDone: begin
          if (pending_q || refresh_i) begin
            pending_q <= 1'b0;
            state_q   <= StLoad;
            slot_q    <= '0;
            busy_q    <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign wen_o    = wen_q;
  assign w_addr_o = addr_q;
  assign w_data_o = data_q;

endmodule
